seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Byte-stream controller for bit-serial sequence detection. Accepts ASCII bytes over a valid/ready handshake, serializes each byte MSB first, and feeds the bits into a pattern-history detector. The pattern is programmable and overlapping matches count.
- Reports the number of matches per byte and keeps a saturating total.
- Sits between the character source (UART RX / testbench feeder) and status/LED logic. It is the sequencing front-end for the team's fixed-pattern detectors.

Parameters:
- DATA_W, 8, bits per input symbol.
- PAT_W, 4, pattern length in bits.
- PAT_RST, 4'b0110, pattern value after reset.
- TOT_W, 16, width of the saturating total-match counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- cfg_we  input  1  pattern load strobe; accepted only in IDLE.
- cfg_pat  input  PAT_W  new pattern.
- flush  input  1  clears bit history; accepted only in IDLE.
- in_valid  input  1  byte available.
- in_data  input  DATA_W  byte.
- in_ready  output  1  high only in IDLE.
- out_valid  output  1  per-byte result valid; high only in DONE.
- out_ready  input  1  result consumed.
- out_hits  output  $clog2(DATA_W+1)  matches completed by bits of this byte.
- out_any  output  1  out_hits != 0.
- total_hits  output  TOT_W  saturating count of all matches since reset.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; pattern=PAT_RST; history=0; hist_len=0; out_hits=0; total_hits=0.
  - Reset values of outputs: in_ready=1, out_valid=0, out_any=0, busy=0.
  - Reset mid-byte aborts the byte silently; the partial result is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_valid&in_ready: latch in_data into shift_reg, clear byte hit counter, set bit_cnt=DATA_W-1, go to SHIFT.
  - cfg_we: load pattern, clear history and hist_len.
  - flush: clear history and hist_len.
  - Priority in the same cycle: cfg_we/flush apply first, then the byte is accepted. The new byte therefore sees the cleared history and new pattern.
- SHIFT, one bit per cycle:
  - history <= {history[PAT_W-2:0], bit}; hist_len saturates at PAT_W.
  - Match when the updated hist_len==PAT_W and the updated history==pattern. On a match, increment the byte hit count and total_hits (saturating at all-ones, no wrap).
  - At bit_cnt==0, go to DONE; otherwise decrement bit_cnt.
  - cfg_we, flush and in_valid are ignored.
- DONE:
  - out_valid=1; out_hits/out_any stable until the handshake.
  - On out_ready, go to IDLE. Simultaneous in_valid is not accepted that cycle (in_ready=0 in DONE).
- Latency: acceptance edge T0; bits consumed on edges T1..T_DATA_W; out_valid visible after edge T_DATA_W. Minimum byte period is DATA_W+2 cycles.
- History persists across bytes: a pattern spanning a byte boundary counts in the byte that supplies its last bit.
- Overlap: matches may share bits. Example: 0110110 contains two matches of 0110.
- Matches need PAT_W valid history bits, so there are no false hits on zeros after reset or flush.

Optional Feature:
- Macro: SEQ_DETECT_CTRL_LSB_FIRST_EN.
- Defined: each byte is serialized LSB first (in_data[0] first).
- Undefined (default): MSB first. All other behaviour is identical.

Decomposition:
- Shared package seq_detect_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - default pattern constant 4'b0110;
  - ASCII constant 'v' = 8'h76.
- One natural sub-module: seq_hist_match. It holds the PAT_W history register, hist_len saturation and the pattern compare, with shift_en/bit/clear inputs and a match output. seq_detect_ctrl instantiates it and holds the FSM, serializer and counters.

Test Plan:
- Reset, then send 0x76 ('v'; bits 0111 0110) -> out_valid after 8 edges, out_hits=1, out_any=1, total_hits=1.
- Send 0x66 -> out_hits=2; then send 0x6D (0110 1101, overlapping) -> out_hits=2, total_hits=4.
- Boundary crossing: flush, send 0x03, then 0x00 -> first out_hits=0, second out_hits=1.
- Config: in IDLE cfg_we with cfg_pat=4'b1111, send 0xFF -> out_hits=5. Also cfg_we asserted during SHIFT -> pattern unchanged.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid/out_hits stable, in_ready=0, second byte not accepted until after the handshake.
- Async rst pulse mid-SHIFT (between clock edges) -> immediate IDLE, in_ready=1, total_hits=0. The next 0x76 gives out_hits=1.
- Saturation: force/preload total_hits to all-ones, send 0x66 -> total_hits stays 16'hFFFF.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the bit-serial sequence detector: controller states
// and the constants the controller and its feeders agree on.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] PAT_DEFAULT = 4'b0110;
  localparam logic [7:0] ASCII_V     = 8'h76;

endpackage

// File: rtl/seq_hist_match.sv
// Bit-history register with a fill counter and pattern compare. match_o is
// combinational and reflects the history as it will be after this cycle's shift.
module seq_hist_match #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             bit_i,
  input  logic             clear_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic             match_o
);

  localparam int LEN_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] len_q, len_d;

  always_comb begin
    hist_d  = hist_q;
    len_d   = len_q;
    match_o = 1'b0;
    if (clear_i) begin
      hist_d = '0;
      len_d  = '0;
    end else if (shift_en_i) begin
      hist_d = {hist_q[PAT_W-2:0], bit_i};
      len_d  = (len_q == LEN_W'(PAT_W)) ? len_q : len_q + 1'b1;
      // A full window is required so that zeros left by reset or a clear
      // never produce a hit on their own.
      match_o = (len_d == LEN_W'(PAT_W)) && (hist_d == pattern_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      len_q  <= '0;
    end else begin
      hist_q <= hist_d;
      len_q  <= len_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Byte-stream front-end: accepts bytes, serializes them into seq_hist_match and
// counts matches per byte and in total. Define SEQ_DETECT_CTRL_LSB_FIRST_EN to
// serialize LSB first instead of MSB first.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int               DATA_W  = 8,
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_DEFAULT),
  parameter int               TOT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [PAT_W-1:0]             cfg_pat,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DATA_W+1)-1:0]  out_hits,
  output logic                         out_any,
  output logic [TOT_W-1:0]             total_hits,
  output logic                         busy
);

  localparam int HIT_W = $clog2(DATA_W + 1);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HIT_W-1:0]  hits_q, hits_d;
  logic [TOT_W-1:0]  total_q, total_d;

  logic ser_bit;
  logic shift_en;
  logic hist_clear;
  logic hit;

`ifdef SEQ_DETECT_CTRL_LSB_FIRST_EN
  assign ser_bit = shift_q[0];
`else
  assign ser_bit = shift_q[DATA_W-1];
`endif

  seq_hist_match #(
    .PAT_W(PAT_W)
  ) u_hist (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (shift_en),
    .bit_i      (ser_bit),
    .clear_i    (hist_clear),
    .pattern_i  (pat_q),
    .match_o    (hit)
  );

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    hits_d     = hits_q;
    total_d    = total_q;
    shift_en   = 1'b0;
    hist_clear = 1'b0;
    case (state_q)
      IDLE: begin
        // Config and flush land on the same edge as acceptance, so the new
        // byte starts from an empty history and the new pattern.
        if (cfg_we) begin
          pat_d      = cfg_pat;
          hist_clear = 1'b1;
        end
        if (flush) begin
          hist_clear = 1'b1;
        end
        if (in_valid) begin
          shift_d = in_data;
          hits_d  = '0;
          cnt_d   = CNT_W'(DATA_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
`ifdef SEQ_DETECT_CTRL_LSB_FIRST_EN
        shift_d = shift_q >> 1;
`else
        shift_d = shift_q << 1;
`endif
        if (hit) begin
          hits_d = hits_q + 1'b1;
          if (total_q != '1) begin
            total_d = total_q + 1'b1;
          end
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= PAT_RST;
      shift_q <= '0;
      cnt_q   <= '0;
      hits_q  <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      hits_q  <= hits_d;
      total_q <= total_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_hits   = hits_q;
  assign out_any    = (hits_q != '0);
  assign total_hits = total_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Randomized self-checking bench for seq_detect_ctrl: a bit-queue model of the
// detector plus a per-cycle compare process; a narrow-total instance exercises saturation.
module tb_seq_detect_ctrl;
  import seq_detect_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_pat = '0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b0;

  logic        in_ready, out_valid, out_any, busy;
  logic [3:0]  out_hits;
  logic [15:0] total_hits;

  logic        s_in_ready, s_out_valid, s_out_any, s_busy;
  logic [3:0]  s_out_hits;
  logic [3:0]  s_total_hits;

  seq_detect_ctrl #(.DATA_W(8), .PAT_W(4), .PAT_RST(4'b0110), .TOT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_hits(out_hits),
    .out_any(out_any), .total_hits(total_hits), .busy(busy)
  );

  seq_detect_ctrl #(.DATA_W(8), .PAT_W(4), .PAT_RST(4'b0110), .TOT_W(4)) dut_small (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_hits(s_out_hits),
    .out_any(s_out_any), .total_hits(s_total_hits), .busy(s_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: last few stream bits, current pattern, true total, expected phase
  // (0 = idle, 1 = shifting, 2 = result held).
  logic       hist_m[$];
  logic [3:0] pat_m = 4'b0110;
  int         total_m = 0;
  int         exp_hits = 0;
  int         phase = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int run_byte(input logic [7:0] b);
    int n = 0;
    logic bv;
    logic [3:0] w;
    for (int i = 0; i < 8; i++) begin
`ifdef SEQ_DETECT_CTRL_LSB_FIRST_EN
      bv = b[i];
`else
      bv = b[7-i];
`endif
      hist_m.push_back(bv);
      if (hist_m.size() > 4) void'(hist_m.pop_front());
      if (hist_m.size() == 4) begin
        w = {hist_m[0], hist_m[1], hist_m[2], hist_m[3]};
        if (w == pat_m) n++;
      end
    end
    return n;
  endfunction

  function automatic void model_reset();
    hist_m.delete();
    pat_m   = 4'b0110;
    total_m = 0;
    phase   = 0;
  endfunction

  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(phase == 0));
    chk("busy", int'(busy), int'(phase != 0));
    chk("out_valid", int'(out_valid), int'(phase == 2));
    if (phase != 1) begin
      chk("total_hits", int'(total_hits), total_m);
      chk("total_sat4", int'(s_total_hits), (total_m > 15) ? 15 : total_m);
    end
    if (phase == 2) begin
      chk("out_hits", int'(out_hits), exp_hits);
      chk("out_any", int'(out_any), int'(exp_hits != 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cfg_we = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic noise();
    in_valid = 1'($urandom); in_data = 8'($urandom);
    cfg_we = 1'($urandom); cfg_pat = 4'($urandom); flush = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    clear_inputs();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic cfg_only(input logic [3:0] p);
    cfg_we = 1'b1; cfg_pat = p;
    tick();
    cfg_we = 1'b0;
    pat_m = p;
    hist_m.delete();
  endtask

  task automatic flush_only();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    hist_m.delete();
  endtask

  // Caller is at posedge+1 with the DUT idle; returns the same way.
  task automatic send_byte(input logic [7:0] b, input bit cfg, input logic [3:0] p,
                           input bit fl, input int hold, input int lit_hits, input int lit_total);
    in_valid = 1'b1; in_data = b; cfg_we = cfg; cfg_pat = p; flush = fl;
    tick();
    if (cfg) begin pat_m = p; hist_m.delete(); end
    if (fl) hist_m.delete();
    exp_hits = run_byte(b);
    total_m  = (total_m + exp_hits > 65535) ? 65535 : total_m + exp_hits;
    phase = 1;
    for (int i = 0; i < 8; i++) begin
      noise();
      out_ready = 1'($urandom);
      tick();
    end
    phase = 2;
    out_ready = 1'b0;
    if (lit_hits >= 0) chk("lit_hits", int'(out_hits), lit_hits);
    if (lit_total >= 0) chk("lit_total", int'(total_hits), lit_total);
    for (int i = 0; i < hold; i++) begin
      noise();
      tick();
    end
    noise();
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    phase = 0;
    clear_inputs();
    $display("byte 0x%02h pat=%b hits=%0d total=%0d hold=%0d", b, pat_m, exp_hits, total_m, hold);
  endtask

  // Asynchronous reset while clk is high, several bits into a byte.
  task automatic rst_mid(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    tick();
    in_valid = 1'b0;
    phase = 1;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_total", int'(total_hits), 0);
    chk("rst_out_any", int'(out_any), 0);
    model_reset();
    rst = 1'b0;
    tick();
    $display("async reset mid-byte 0x%02h", b);
  endtask

  initial begin
    int r;
    repeat (2) tick();
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_hits", int'(out_hits), 0);
    chk("reset_out_any", int'(out_any), 0);
    chk("reset_total", int'(total_hits), 0);
    rst = 1'b0;
    tick();

    send_byte(ASCII_V, 0, 4'h0, 0, 0, 1, 1);
    do_reset();
    send_byte(8'h66, 0, 4'h0, 0, 0, 2, 2);
    send_byte(8'h6D, 0, 4'h0, 0, 0, 2, 4);
    flush_only();
    send_byte(8'h03, 0, 4'h0, 0, 0, 0, -1);
    send_byte(8'h00, 0, 4'h0, 0, 0, 1, -1);
    send_byte(8'hFF, 1, 4'b1111, 0, 0, 5, -1);
    send_byte(8'hFF, 0, 4'h0, 0, 0, 8, -1);
    send_byte(ASCII_V, 1, 4'b0110, 0, 10, 1, -1);
    rst_mid(ASCII_V);
    send_byte(ASCII_V, 0, 4'h0, 0, 0, 1, 1);

    cfg_only(4'b1111);
    send_byte(8'hFF, 0, 4'h0, 0, 0, 5, -1);
    send_byte(8'hFF, 0, 4'h0, 0, 0, 8, -1);
    send_byte(8'hFF, 0, 4'h0, 0, 1, 8, -1);
    send_byte(8'h66, 1, 4'b0110, 0, 0, 2, -1);
    chk("sat_small_total", int'(s_total_hits), 15);

    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) flush_only();
      else if (r == 1) cfg_only(4'($urandom));
      else send_byte(8'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom),
                     ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
